fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32 pipeline. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Returned instructions are buffered in a small prefetch FIFO and presented to decode as de_insn/de_pc with a valid/ready handshake.
- Execute-stage redirects (branches/jumps) flush the FIFO and retarget fetch.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.
- DEPTH, 2, prefetch FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_req  output  1  read request, registered.
- imem_addr  output  32  word address of request, registered, bits[1:0]=0.
- imem_ack  input  1  transfer completes in any cycle with imem_req && imem_ack.
- imem_rdata  input  32  instruction word, valid when imem_ack.
- de_valid  output  1  FIFO head valid.
- de_ready  input  1  decode accepts head; pop when de_valid && de_ready.
- de_insn  output  32  FIFO head instruction.
- de_pc  output  32  FIFO head PC.
- redirect_valid  input  1  flush and retarget, one-cycle pulse from execute.
- redirect_pc  input  32  new target; bits[1:0] ignored, treated as 0.

Behaviour:
- Reset (async assert, sync-safe release): fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, FIFO empty, de_valid=0, de_insn=32'h00000013 (addi x0,x0,0), de_pc=RESET_PC, discard=0, pending_valid=0.
- States: IDLE (no request), REQ (request outstanding), DRAIN (request outstanding but result to be discarded).
- Request rule:
  - At most one outstanding request.
  - imem_req rises only when the FIFO count after this cycle's push/pop is < DEPTH. This guarantees space when the ack arrives.
  - imem_req and imem_addr hold stable until ack.
  - Back-to-back: on ack, the next request may be asserted the following cycle at fetch_pc+4.
- Ack in REQ: push {imem_addr, imem_rdata}; fetch_pc += 4 (mod 2^32, wrap at 0xFFFFFFFC -> 0).
- Latency: an ack in cycle N makes the entry visible on de_valid in cycle N+1. There is no combinational bypass from imem_rdata to de_insn.
- FIFO:
  - Simultaneous push and pop is allowed at any count, including full (pop frees the slot).
  - When empty, de_insn/de_pc hold their last values.
  - Pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
- Redirect (redirect_valid=1), highest priority:
  - FIFO flushed next cycle (de_valid=0), regardless of any pop or ack in the same cycle.
  - A same-cycle ack is dropped.
  - IDLE, or REQ with a same-cycle ack: fetch_pc=redirect_pc&~3; new request may issue next cycle.
  - REQ without ack: go to DRAIN. imem_req/imem_addr stay unchanged; redirect_pc&~3 is stored as pending.
  - In DRAIN, the ack data is discarded. The following cycle, fetch_pc=pending and normal fetch resumes.
  - A second redirect while in DRAIN overwrites pending.
- Reset mid-operation: all state returns to reset values immediately, and the outstanding request is abandoned. Memory is reset alongside.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32.
  - NOP_INSN=32'h00000013.
  - Fetch state enum {FS_IDLE, FS_REQ, FS_DRAIN}.
- Natural sub-module: fetch_fifo. It is a synchronous DEPTH x 64-bit FIFO with push, pop, flush, count, head outputs.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req) returning addr-as-data -> de_pc sequence 0x0,0x4,0x8 with de_insn equal to de_pc; one insn per cycle after 2-cycle startup.
- de_ready=0 for 10 cycles -> exactly DEPTH (2) entries fetched, imem_req low while full. Raise de_ready -> entries 0x0,0x4 delivered in order, then fetch resumes at 0x8.
- Ack delayed 3 cycles; redirect_pc=0x100 pulsed in wait cycle 1 -> imem_addr stays 0x8 until ack, that data is never presented, next imem_addr=0x100, first de_pc=0x100.
- Redirect to 0x203 in the same cycle as ack, pop and full FIFO -> de_valid=0 next cycle, next imem_addr=0x200.
- Memory returning 0x00002013 at 0x10 -> delivered to decode with de_pc=0x10. Also: fetch_pc=0xFFFFFFFC wraps to 0x0.
- reset_n pulsed low mid-request with FIFO holding 1 entry -> all outputs at reset values asynchronously. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32 pipeline types and constants used by the fetch stage.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h00000013;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_DRAIN
  } fetch_state_t;

  // Prefetch buffer entry; pc sits in the upper half of the 64-bit word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and decode; head holds its last
// value while empty so decode sees stable (if invalid) fields.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int           DEPTH       = 2,
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // A pop frees its slot in the same cycle, so push is legal even when full.
  assign do_push    = push && ((count < FULL_CNT) || do_pop);
  assign head       = head_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= RESET_ENTRY;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_ENTRY;
    end else begin
      if (head_valid) last_q <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: single-outstanding imem requests feeding a prefetch
// FIFO toward decode, with execute redirects flushing and retargeting fetch.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_insn,
  output logic [XLEN-1:0] de_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pending_q, pending_d;
  logic [XLEN-1:0] addr_d, redir_tgt;
  logic            req_d, ack, push, pop, flush, advance;
  logic [PW:0]     fifo_count, count_nxt;
  fetch_entry_t    push_entry, head;

  assign redir_tgt  = redirect_pc & ~32'h3;
  assign ack        = imem_req && imem_ack;
  assign flush      = redirect_valid;
  // A redirect drops any same-cycle ack; in DRAIN the ack is always dropped.
  assign push       = ack && (state_q == FS_REQ) && !redirect_valid;
  assign pop        = de_valid && de_ready;
  assign push_entry = {imem_addr, imem_rdata};
  // Occupancy after this cycle; a new request only issues if that leaves room.
  assign count_nxt  = flush ? '0 : fifo_count + (PW+1)'(push) - (PW+1)'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    req_d      = imem_req;
    addr_d     = imem_addr;
    advance    = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        if (redirect_valid) fetch_pc_d = redir_tgt;
        advance = 1'b1;
      end
      FS_REQ: begin
        if (redirect_valid && !ack) begin
          state_d   = FS_DRAIN;
          pending_d = redir_tgt;
        end else if (ack) begin
          fetch_pc_d = redirect_valid ? redir_tgt : fetch_pc_q + 32'd4;
          advance    = 1'b1;
        end
      end
      FS_DRAIN: begin
        if (redirect_valid) pending_d = redir_tgt;
        if (ack) begin
          fetch_pc_d = pending_d;
          advance    = 1'b1;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    // Request bus is free this cycle: issue at fetch_pc_d if the FIFO has room.
    if (advance) begin
      if (count_nxt < FULL_CNT) begin
        state_d = FS_REQ;
        req_d   = 1'b1;
        addr_d  = fetch_pc_d;
      end else begin
        state_d = FS_IDLE;
        req_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      pending_q  <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .RESET_ENTRY({RESET_PC, NOP_INSN})
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head_valid(de_valid),
    .head      (head)
  );

  assign de_insn = head.insn;
  assign de_pc   = head.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable imem model, scoreboard of
// expected decode deliveries, redirect vector table and hand-written corners.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_ack, de_valid, de_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, de_insn, de_pc, redirect_pc;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int wait_cnt, ack_cnt;

  typedef struct packed { logic [31:0] pc; logic [31:0] insn; } exp_t;
  typedef struct { logic [31:0] rpc, pc0, insn0, pc1, insn1; } vec_t;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[5];

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .de_valid(de_valid),
    .de_ready(de_ready), .de_insn(de_insn), .de_pc(de_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00002013 : a;
  endfunction

  // Memory answers mem_lat cycles after the request appears (0 = same cycle).
  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = imem_ack ? mem_data(imem_addr) : 32'hDEADBEEF;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 0;
      ack_cnt  <= 0;
    end else if (imem_req && imem_ack) begin
      wait_cnt <= 0;
      ack_cnt  <= ack_cnt + 1;
    end else if (imem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && de_valid && de_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra got pc %h insn %h want nothing", de_pc, de_insn);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", de_pc, mon_e.pc);
        check("sb_insn", de_insn, mon_e.insn);
      end
    end
  end

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({start + 32'(4*k), mem_data(start + 32'(4*k))});
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 0);
  endtask

  task automatic expect_req(input string name, input logic [31:0] addr);
    int n;
    n = 0;
    while (!imem_req && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_req"}, 32'(imem_req), 1);
    check({name, "_addr"}, imem_addr, addr);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Redirect to 0x203 while popping: lat 0 -> full FIFO, idle bus;
  // lat 1 -> coincident with the ack of the second fetch.
  task automatic redir_pop(input int lat);
    bit found;
    do_reset();
    mem_lat = lat;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (lat == 0) found = (ack_cnt == 2) && !imem_req;
      else          found = imem_req && imem_ack && (imem_addr == 32'h4);
    end
    check("rp_setup", 32'(found), 1);
    exp_q.push_back({32'h0, mem_data(32'h0)});
    de_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    de_ready = 1'b0;
    check("rp_flush", de_valid, 0);
    expect_req("rp", 32'h200);
    expect_seq(32'h200, 2);
    de_ready = 1'b1;
    drain("rp", 30);
    de_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h10,       32'h10,       32'h00002013, 32'h14,       32'h14};
    vecs[1] = '{32'h203,      32'h200,      32'h200,      32'h204,      32'h204};
    vecs[2] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0};
    vecs[3] = '{32'h1001,     32'h1000,     32'h1000,     32'h1004,     32'h1004};
    vecs[4] = '{32'h7FFFFFFE, 32'h7FFFFFFC, 32'h7FFFFFFC, 32'h80000000, 32'h80000000};
    redirect_valid = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;

    // Reset values
    @(posedge clk); #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", de_valid, 0);
    check("rst_insn", de_insn, 32'h00000013);
    check("rst_pc", de_pc, 32'h0);

    // Zero-wait memory: one instruction per cycle after 2-cycle startup
    do_reset();
    mem_lat = 0;
    de_ready = 1'b1;
    expect_seq(32'h0, 8);
    @(posedge clk); #1;
    check("zw_req", imem_req, 1);
    check("zw_addr", imem_addr, 32'h0);
    check("zw_valid0", de_valid, 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("zw_stream", de_valid, 1);
    end
    drain("zw", 10);
    de_ready = 1'b0;

    // Backpressure: exactly DEPTH fetched, then resume at 0x8
    do_reset();
    mem_lat = 0;
    repeat (10) @(posedge clk);
    #1;
    check("bp_acks", 32'(ack_cnt), 2);
    check("bp_req_low", imem_req, 0);
    check("bp_valid", de_valid, 1);
    check("bp_head", de_pc, 32'h0);
    expect_seq(32'h0, 4);
    de_ready = 1'b1;
    drain("bp", 30);
    de_ready = 1'b0;

    // Delayed ack with redirect in wait cycle 1: old data discarded
    do_reset();
    mem_lat = 3;
    de_ready = 1'b1;
    expect_seq(32'h0, 2);
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(posedge clk); #1;
        found = imem_req && (imem_addr == 32'h8);
      end
      check("dl_setup", 32'(found), 1);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("dl_hold_addr", imem_addr, 32'h8);
      check("dl_hold_req", imem_req, 1);
      if (imem_ack) break;
      @(posedge clk); #1;
    end
    expect_seq(32'h100, 2);
    @(posedge clk); #1;
    expect_req("dl", 32'h100);
    drain("dl", 40);
    de_ready = 1'b0;

    redir_pop(1);
    redir_pop(0);

    // Redirect vector table across memory latencies
    for (int i = 0; i < 5; i++) begin
      mem_lat = i % 3;
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc = vecs[i].rpc;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      check("tbl_flush", de_valid, 0);
      exp_q.push_back({vecs[i].pc0, vecs[i].insn0});
      exp_q.push_back({vecs[i].pc1, vecs[i].insn1});
      de_ready = 1'b1;
      drain("tbl", 40);
      de_ready = 1'b0;
    end

    // Asynchronous reset mid-request with one entry buffered
    do_reset();
    mem_lat = 3;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(posedge clk); #1;
        found = (ack_cnt == 1) && imem_req;
      end
      check("ar_setup", 32'(found), 1);
    end
    check("ar_pre_valid", de_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    check("ar_req", imem_req, 0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_valid", de_valid, 0);
    check("ar_insn", de_insn, 32'h00000013);
    check("ar_pc", de_pc, 32'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    mem_lat = 0;
    expect_seq(32'h0, 3);
    de_ready = 1'b1;
    drain("ar", 20);
    de_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
